decoder_2to4_stream: RTL and testbench

DECODER_2TO4_STREAM -- requirements
Module: decoder_2to4_stream

---
 rtl/decoder_pkg.sv | 21 ++
 rtl/decoder_2to4_stream_if.sv | 24 ++
 rtl/decoder_2to4_stream_skid.sv | 73 +++++++
 rtl/decoder_2to4_stream.sv | 68 ++++++
 tb/tb_decoder_2to4_stream.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/decoder_pkg.sv
// Shared types and constants for the 2-to-4 streaming decoder.
// Holds the buffer state encoding and the decode helper used by the top.
package decoder_pkg;

  localparam int NUM_LINES = 4;
  localparam int PAYLOAD_W = NUM_LINES + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Payload layout is {none, onehot}; a disabled word carries no active line.
  function automatic logic [PAYLOAD_W-1:0] decode_word(input logic en, input logic [1:0] code);
    logic [NUM_LINES-1:0] oh;
    oh = en ? (NUM_LINES'(1) << code) : '0;
    return {~en, oh};
  endfunction

endpackage

// File: rtl/decoder_2to4_stream_if.sv
// Valid/ready stream bundle for the decoder: code words in, one-hot words out.
// The slave modport is the decoder's view; master is the surrounding logic.
interface decoder_2to4_stream_if;

  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_code;
  logic       in_en;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_onehot;
  logic       out_none;

  modport slave (
    input  in_valid, in_code, in_en, out_ready,
    output in_ready, out_valid, out_onehot, out_none
  );

  modport master (
    output in_valid, in_code, in_en, out_ready,
    input  in_ready, out_valid, out_onehot, out_none
  );

endinterface

// File: rtl/decoder_2to4_stream_skid.sv
// Two-entry in-order buffer (output register plus skid register).
// in_ready depends only on the state register, never on out_ready.
module dec_skid
  import decoder_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  state_e         state_q, state_d;
  logic [W-1:0]   out_q, out_d;
  logic [W-1:0]   skid_q, skid_d;
  logic           accept, pop;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = out_q;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          out_d   = in_data;
        end
      end
      ONE: begin
        if (accept && !pop) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (!accept && pop) begin
          state_d = EMPTY;
        end else if (accept && pop) begin
          out_d = in_data;
        end
      end
      FULL: begin
        // The older word sits in out_q, so the skid word moves up on a pop.
        if (pop) begin
          state_d = ONE;
          out_d   = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

endmodule

// File: rtl/decoder_2to4_stream.sv
// Streaming 2-to-4 line decoder with per-line saturating hit counters.
// Decode happens before buffering so the skid entries hold finished words.
module decoder_2to4_stream
  import decoder_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  decoder_2to4_stream_if.slave         bus,
  input  logic                         clr_cnt,
  output logic [NUM_LINES*CNT_W-1:0]   hit_cnt
);

  logic [PAYLOAD_W-1:0] in_word;
  logic [PAYLOAD_W-1:0] out_word;
  logic                 accept;
  logic [CNT_W-1:0]     cnt_q [NUM_LINES];
  logic [CNT_W-1:0]     cnt_d [NUM_LINES];

  assign in_word = decode_word(bus.in_en, bus.in_code);
  assign accept  = bus.in_valid && bus.in_ready;
  assign {bus.out_none, bus.out_onehot} = out_word;

  dec_skid #(
    .W (PAYLOAD_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_word),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_word)
  );

  // Clear wins over a same-cycle hit; a full counter stays at its maximum.
  always_comb begin
    for (int k = 0; k < NUM_LINES; k++) begin
      cnt_d[k] = cnt_q[k];
    end
    if (clr_cnt) begin
      for (int k = 0; k < NUM_LINES; k++) begin
        cnt_d[k] = '0;
      end
    end else if (accept && bus.in_en && (cnt_q[bus.in_code] != '1)) begin
      cnt_d[bus.in_code] = cnt_q[bus.in_code] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_LINES; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_LINES; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_pack
    assign hit_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_decoder_2to4_stream.sv
// Self-checking bench for decoder_2to4_stream: directed vector table,
// handwritten backpressure/saturation/reset sequences, then random traffic.
module tb_decoder_2to4_stream;

  localparam int CNT_W = 8;

  typedef struct {
    logic       en;
    logic [1:0] code;
    logic [3:0] expOnehot;
    logic       expNone;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        clr_cnt;
  logic [31:0] hit_cnt;
  int          checks;
  int          errors;
  int          expCnt [4];
  logic [4:0]  sbQueue [$];
  vec_t        vectors [6];

  decoder_2to4_stream_if bus();

  decoder_2to4_stream #(
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .clr_cnt (clr_cnt),
    .hit_cnt (hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic valid, input logic en, input logic [1:0] code,
                               input logic outReady, input logic clr);
    bus.in_valid  = valid;
    bus.in_en     = en;
    bus.in_code   = code;
    bus.out_ready = outReady;
    clr_cnt       = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] packCnt();
    logic [31:0] p;
    for (int k = 0; k < 4; k++) p[k*8 +: 8] = expCnt[k][7:0];
    return p;
  endfunction

  function automatic void bumpCnt(input logic en, input logic [1:0] code);
    if (en && expCnt[code] < 255) expCnt[code]++;
  endfunction

  function automatic void clearCnt();
    for (int k = 0; k < 4; k++) expCnt[k] = 0;
  endfunction

  // Independent reference decode written as a lookup rather than a shift.
  function automatic logic [4:0] refWord(input logic en, input logic [1:0] code);
    if (!en) return 5'b1_0000;
    case (code)
      2'd0:    return 5'b0_0001;
      2'd1:    return 5'b0_0010;
      2'd2:    return 5'b0_0100;
      default: return 5'b0_1000;
    endcase
  endfunction

  initial begin
    logic       rv, ren, rrdy, acc, pop, ok;
    logic [1:0] rcode;

    checks = 0;
    errors = 0;
    clearCnt();
    vectors[0] = '{en: 1'b1, code: 2'd0, expOnehot: 4'b0001, expNone: 1'b0};
    vectors[1] = '{en: 1'b1, code: 2'd1, expOnehot: 4'b0010, expNone: 1'b0};
    vectors[2] = '{en: 1'b1, code: 2'd2, expOnehot: 4'b0100, expNone: 1'b0};
    vectors[3] = '{en: 1'b1, code: 2'd3, expOnehot: 4'b1000, expNone: 1'b0};
    vectors[4] = '{en: 1'b0, code: 2'd2, expOnehot: 4'b0000, expNone: 1'b1};
    vectors[5] = '{en: 1'b0, code: 2'd0, expOnehot: 4'b0000, expNone: 1'b1};

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    step();
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_onehot", bus.out_onehot, 0);
    checkOutput("rst_none", bus.out_none, 0);
    checkOutput("rst_hit_cnt", hit_cnt, 0);
    rst_n = 1'b1;
    step();

    // Back-to-back streaming through the vector table.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, vectors[i].en, vectors[i].code, 1'b1, 1'b0);
      bumpCnt(vectors[i].en, vectors[i].code);
      step();
      checkOutput($sformatf("vec%0d_valid", i), bus.out_valid, 1);
      checkOutput($sformatf("vec%0d_onehot", i), bus.out_onehot, vectors[i].expOnehot);
      checkOutput($sformatf("vec%0d_none", i), bus.out_none, vectors[i].expNone);
      checkOutput($sformatf("vec%0d_in_ready", i), bus.in_ready, 1);
      checkOutput($sformatf("vec%0d_hit_cnt", i), hit_cnt, packCnt());
    end
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    step();
    checkOutput("stream_drain_valid", bus.out_valid, 0);

    // Backpressure: two words fill the buffer, the third waits.
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
    bumpCnt(1'b1, 2'd0);
    step();
    checkOutput("bp_a_onehot", bus.out_onehot, 4'b0001);
    checkOutput("bp_a_in_ready", bus.in_ready, 1);
    applyStimulus(1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
    bumpCnt(1'b1, 2'd1);
    step();
    checkOutput("bp_b_in_ready", bus.in_ready, 0);
    checkOutput("bp_b_hold_onehot", bus.out_onehot, 4'b0001);
    applyStimulus(1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    step();
    checkOutput("bp_c_stall_in_ready", bus.in_ready, 0);
    checkOutput("bp_c_hold_onehot", bus.out_onehot, 4'b0001);
    checkOutput("bp_c_stall_hit_cnt", hit_cnt, packCnt());
    applyStimulus(1'b1, 1'b1, 2'd2, 1'b1, 1'b0);
    step();
    checkOutput("bp_pop1_onehot", bus.out_onehot, 4'b0010);
    checkOutput("bp_pop1_in_ready", bus.in_ready, 1);
    bumpCnt(1'b1, 2'd2);
    step();
    checkOutput("bp_pop2_onehot", bus.out_onehot, 4'b0100);
    checkOutput("bp_pop2_valid", bus.out_valid, 1);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    step();
    checkOutput("bp_drain_valid", bus.out_valid, 0);
    checkOutput("bp_hit_cnt", hit_cnt, packCnt());

    // Saturation of line 1, then clear racing an accept.
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
    clearCnt();
    step();
    checkOutput("clr_hit_cnt", hit_cnt, 0);
    applyStimulus(1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      bumpCnt(1'b1, 2'd1);
      step();
    end
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    step();
    checkOutput("sat_hit_cnt", hit_cnt, 32'h0000_FF00);
    checkOutput("sat_model_hit_cnt", hit_cnt, packCnt());
    applyStimulus(1'b1, 1'b1, 2'd3, 1'b1, 1'b1);
    clearCnt();
    step();
    checkOutput("clr_acc_hit_cnt", hit_cnt, 0);
    checkOutput("clr_acc_onehot", bus.out_onehot, 4'b1000);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    step();

    // Reset while FULL, with an accept and clear offered on the reset edge.
    applyStimulus(1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 1'b1, 2'd3, 1'b0, 1'b0);
    step();
    checkOutput("full_in_ready", bus.in_ready, 0);
    checkOutput("full_hit_cnt", hit_cnt, 32'h0101_0000);
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b1, 1'b1);
    step();
    checkOutput("rstfull_out_valid", bus.out_valid, 0);
    checkOutput("rstfull_in_ready", bus.in_ready, 1);
    checkOutput("rstfull_hit_cnt", hit_cnt, 0);
    checkOutput("rstfull_onehot", bus.out_onehot, 0);
    rst_n = 1'b1;
    clearCnt();
    applyStimulus(1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
    bumpCnt(1'b1, 2'd1);
    step();
    checkOutput("after_rst_onehot", bus.out_onehot, 4'b0010);
    checkOutput("after_rst_hit_cnt", hit_cnt, packCnt());
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    step();
    checkOutput("after_rst_drain", bus.out_valid, 0);

    // Random traffic against a queue scoreboard and counter model.
    for (int i = 0; i < 600; i++) begin
      rv    = 1'($urandom_range(0, 1));
      ren   = ($urandom_range(0, 3) != 0);
      rrdy  = 1'($urandom_range(0, 1));
      rcode = 2'($urandom_range(0, 3));
      applyStimulus(rv, ren, rcode, rrdy, 1'b0);
      checkOutput("rnd_in_ready", bus.in_ready, (sbQueue.size() < 2) ? 1 : 0);
      checkOutput("rnd_out_valid", bus.out_valid, (sbQueue.size() > 0) ? 1 : 0);
      acc = rv && bus.in_ready;
      pop = bus.out_valid && rrdy;
      if (pop && sbQueue.size() > 0) begin
        checkOutput("rnd_word", {bus.out_none, bus.out_onehot}, sbQueue[0]);
        void'(sbQueue.pop_front());
      end
      if (acc) begin
        sbQueue.push_back(refWord(ren, rcode));
        bumpCnt(ren, rcode);
      end
      step();
      checkOutput("rnd_hit_cnt", hit_cnt, packCnt());
      if (bus.out_valid) begin
        ok = bus.out_none ? (bus.out_onehot == 4'b0000) : $onehot(bus.out_onehot);
        checkOutput("rnd_onehot_inv", ok, 1);
      end
    end
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (bus.out_valid && sbQueue.size() > 0) begin
        checkOutput("drain_word", {bus.out_none, bus.out_onehot}, sbQueue[0]);
        void'(sbQueue.pop_front());
      end
      step();
    end
    checkOutput("drain_queue_empty", sbQueue.size(), 0);
    checkOutput("drain_out_valid", bus.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
